// File: rtl/touch_cv_slew.sv
// Touch-to-CV core: four channels (direct / touch-hold / gate) each followed by a one-pole slew limiter,
// time-multiplexed one channel per clk after each sample_clk rising edge. Optional: TOUCH_CV_PASSTHROUGH_EN.
module touch_cv_slew #(
  parameter int                     W            = 16,
  parameter int                     SCALE_SHIFT  = W - 10,
  parameter int                     SLEW_SHIFT   = 2,
  parameter logic [7:0]             TOUCH_THRESH = 8'd16,
  parameter logic signed [W-1:0]    GATE_HIGH    = W'(16000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  input  logic [7:0]          jack,
  input  logic [7:0]          touch0,
  input  logic [7:0]          touch1,
  input  logic [7:0]          touch2,
  input  logic [7:0]          touch3,
  input  logic [7:0]          touch4,
  input  logic [7:0]          touch5,
  input  logic [7:0]          touch6,
  input  logic [7:0]          touch7,
  input  logic [7:0]          mode,
  output logic [1:0]          o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PROC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic signed [W+1:0] SAT_MAX = $signed({3'b000, {(W-1){1'b1}}});
  localparam logic signed [W+1:0] SAT_MIN = $signed({3'b111, {(W-1){1'b0}}});

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_ch;
  logic                r_sample_clk;
  logic                w_edge;
  logic signed [W-1:0] r_acc  [4];
  logic signed [W-1:0] r_held [4];
  logic signed [W-1:0] r_out  [4];

  logic [7:0]          w_t;
  logic [1:0]          w_md;
  logic                w_plug;
  logic                w_touched;
  logic signed [W-1:0] w_sin;
  logic [W-1:0]        w_t_ext;
  logic signed [W-1:0] w_scaled;
  logic signed [W-1:0] w_target;
  logic signed [W-1:0] w_acc_cur;
  logic signed [W:0]   w_diff;
  logic signed [W:0]   w_step;
  logic signed [W+1:0] w_sum;
  logic signed [W-1:0] w_acc_next;
  logic signed [W-1:0] w_held_next;
  logic                w_unused;

  assign w_edge  = sample_clk & ~r_sample_clk;
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ch         <= 2'd0;
      r_sample_clk <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sample_clk <= sample_clk;
      r_ch         <= (r_state == ST_PROC) ? r_ch + 2'd1 : 2'd0;
    end
  end

  // Edges seen outside IDLE are simply ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_edge) w_state_next = ST_PROC;
      ST_PROC:   if (r_ch == 2'd3) w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_t   = touch0;
    w_sin = sample_in0;
    case (r_ch)
      2'd1:    begin w_t = touch1; w_sin = sample_in1; end
      2'd2:    begin w_t = touch2; w_sin = sample_in2; end
      2'd3:    begin w_t = touch3; w_sin = sample_in3; end
      default: begin w_t = touch0; w_sin = sample_in0; end
    endcase
  end

  assign w_md      = mode[{r_ch, 1'b0} +: 2];
  assign w_plug    = jack[r_ch];
  assign w_touched = (w_t >= TOUCH_THRESH);
  assign w_t_ext   = {{(W-8){1'b0}}, w_t};
  assign w_scaled  = $signed(w_t_ext << SCALE_SHIFT);
  assign w_acc_cur = r_acc[r_ch];

  always_comb begin
    w_held_next = r_held[r_ch];
    case (w_md)
      2'd1: begin
        if (w_touched) begin
          w_target    = w_scaled;
          w_held_next = w_scaled;
        end else begin
          w_target = r_held[r_ch];
        end
      end
      2'd2:    w_target = w_touched ? GATE_HIGH : '0;
      default: w_target = w_scaled;
    endcase

    // One extra bit keeps target-acc exact; a +/-1 floor step guarantees exact convergence.
    w_diff = $signed({w_target[W-1], w_target}) - $signed({w_acc_cur[W-1], w_acc_cur});
    w_step = w_diff >>> SLEW_SHIFT;
    if ((w_step == '0) && (w_diff != '0))
      w_step = w_diff[W] ? {(W+1){1'b1}} : {{W{1'b0}}, 1'b1};
    w_sum = $signed({{2{w_acc_cur[W-1]}}, w_acc_cur}) + $signed({w_step[W], w_step});

    if (w_sum > SAT_MAX)      w_acc_next = SAT_MAX[W-1:0];
    else if (w_sum < SAT_MIN) w_acc_next = SAT_MIN[W-1:0];
    else                      w_acc_next = w_sum[W-1:0];

    if (w_plug) begin
      w_held_next = '0;
`ifdef TOUCH_CV_PASSTHROUGH_EN
      w_acc_next  = w_sin;
`else
      w_acc_next  = '0;
`endif
    end
  end

`ifdef TOUCH_CV_PASSTHROUGH_EN
  assign w_unused = ^{touch4, touch5, touch6, touch7, jack[7:4]};
`else
  assign w_unused = ^{touch4, touch5, touch6, touch7, jack[7:4], w_sin};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_acc[i]  <= '0;
        r_held[i] <= '0;
        r_out[i]  <= '0;
      end
    end else begin
      if (r_state == ST_PROC) begin
        r_acc[r_ch]  <= w_acc_next;
        r_held[r_ch] <= w_held_next;
      end
      if (r_state == ST_COMMIT) begin
        for (int i = 0; i < 4; i++) r_out[i] <= r_acc[i];
      end
    end
  end

  assign sample_out0 = r_out[0];
  assign sample_out1 = r_out[1];
  assign sample_out2 = r_out[2];
  assign sample_out3 = r_out[3];

endmodule
